param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 95 +++++++++
 tb/tb_param_updown_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Fully synchronous modulo-MODULUS up/down counter with synchronous clear,
//   parallel load, terminal-count flag, one-cycle wrap pulse and a sticky
//   wrap (overflow) flag.
//
// Parameters
//   WIDTH    counter width in bits, 2..32
//   MODULUS  count sequence length, 2..2**WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (q, wrap, ovf -> 0)
//   en     in   count enable (0 = hold)
//   up     in   direction (1 = up, 0 = down)
//   clr    in   synchronous clear, highest priority, also clears ovf
//   load   in   synchronous load of d (saturated to MODULUS-1)
//   d      in   load value
//   q      out  registered count, always < MODULUS
//   tc     out  combinational terminal count: this edge will wrap
//   wrap   out  registered pulse, high for the cycle after a wrapping edge
//   ovf    out  sticky wrap flag, cleared by clr or reset
module param_updown_counter #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   // MODULUS itself may be 2**WIDTH, so it needs one extra bit; nothing
   // else in the datapath is wider than WIDTH.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("param_updown_counter: WIDTH out of range 2..32");
   end
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("param_updown_counter: MODULUS out of range 2..2**WIDTH");
   end

   logic [WIDTH-1:0] q_nxt;

   // tc only reflects a counting edge; clr/load override counting so they
   // suppress it. While reset is low q is 0, so tc follows from that.
   always_comb begin
      tc = 1'b0;
      if (en && !clr && !load)
         tc = up ? (q == MAXV) : (q == '0);
   end

   // When MODULUS == 2**WIDTH the explicit wrap compares coincide with
   // natural WIDTH-bit overflow, so one form serves every modulus.
   always_comb begin
      q_nxt = q;
      if (clr)
         q_nxt = '0;
      else if (load)
         q_nxt = ({1'b0, d} < MOD_EXT) ? d : MAXV;
      else if (en) begin
         if (up)
            q_nxt = (q == MAXV) ? '0 : q + ONE;
         else
            q_nxt = (q == '0) ? MAXV : q - ONE;
      end
   end

   // wrap is a true one-cycle pulse: it re-samples tc every edge, so it
   // drops after one cycle even if counting pauses right after a wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= tc;
         if (clr)
            ovf <= 1'b0;
         else if (tc)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, clr, load;
   logic [3:0] d;
   logic [3:0] q10, q16;
   logic       tc10, wrap10, ovf10, tc16, wrap16, ovf16;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
      .d(d), .q(q10), .tc(tc10), .wrap(wrap10), .ovf(ovf10));

   param_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
      .d(d), .q(q16), .tc(tc16), .wrap(wrap16), .ovf(ovf16));

   // inputs change and outputs are sampled 2 time units after the edge
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      reset = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd7;
      #3;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q10); end
      n_chk++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap10); end
      n_chk++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf10); end
      load = 1'b1;
      tick; tick;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL reset_ignores_inputs: got %0d want 0", q10); end
      load = 1'b0; en = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_count_up;
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         #1;
         n_chk++; if (tc10 !== (i == 10)) begin n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc10, (i == 10)); end
         tick;
         n_chk++; if (q10 !== 4'(i % 10)) begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q10, i % 10); end
         n_chk++; if (wrap10 !== (i == 10)) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap10, (i == 10)); end
         n_chk++; if (ovf10 !== (i >= 10)) begin n_fail++; $display("FAIL up_ovf[%0d]: got %b want %b", i, ovf10, (i >= 10)); end
      end
      en = 1'b0;
   endtask

   task automatic test_count_down;
      logic [3:0] exp_q [3] = '{4'd9, 4'd8, 4'd7};
      clr = 1'b1; tick; clr = 1'b0;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL clr_q: got %0d want 0", q10); end
      n_chk++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", ovf10); end
      en = 1'b1; up = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (tc10 !== (k == 0)) begin n_fail++; $display("FAIL dn_tc[%0d]: got %b want %b", k, tc10, (k == 0)); end
         tick;
         n_chk++; if (q10 !== exp_q[k]) begin n_fail++; $display("FAIL dn_q[%0d]: got %0d want %0d", k, q10, exp_q[k]); end
         n_chk++; if (wrap10 !== (k == 0)) begin n_fail++; $display("FAIL dn_wrap[%0d]: got %b want %b", k, wrap10, (k == 0)); end
      end
      en = 1'b0;
   endtask

   task automatic test_hold;
      clr = 1'b1; tick; clr = 1'b0;
      en = 1'b1; up = 1'b1;
      repeat (5) tick;
      n_chk++; if (q10 !== 4'd5) begin n_fail++; $display("FAIL hold_pre_q: got %0d want 5", q10); end
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_chk++; if (tc10 !== 1'b0) begin n_fail++; $display("FAIL hold_tc[%0d]: got %b want 0", k, tc10); end
         tick;
         n_chk++; if (q10 !== 4'd5) begin n_fail++; $display("FAIL hold_q[%0d]: got %0d want 5", k, q10); end
         n_chk++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL hold_wrap[%0d]: got %b want 0", k, wrap10); end
      end
      en = 1'b1; tick; en = 1'b0;
      n_chk++; if (q10 !== 4'd6) begin n_fail++; $display("FAIL hold_resume_q: got %0d want 6", q10); end
      n_chk++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL hold_resume_wrap: got %b want 0", wrap10); end
   endtask

   task automatic test_load;
      load = 1'b1; d = 4'd7; tick;
      n_chk++; if (q10 !== 4'd7) begin n_fail++; $display("FAIL load7_q: got %0d want 7", q10); end
      d = 4'd13; tick;
      n_chk++; if (q10 !== 4'd9) begin n_fail++; $display("FAIL load13_q: got %0d want 9", q10); end
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1;
      n_chk++; if (tc10 !== 1'b1) begin n_fail++; $display("FAIL load_tc9: got %b want 1", tc10); end
      tick;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL load_wrap_q: got %0d want 0", q10); end
      n_chk++; if (ovf10 !== 1'b1) begin n_fail++; $display("FAIL load_wrap_ovf: got %b want 1", ovf10); end
      en = 1'b0; load = 1'b1; d = 4'd9; tick;
      // load overrides counting at terminal count: no tc, no wrap
      en = 1'b1; up = 1'b1; d = 4'd2;
      #1;
      n_chk++; if (tc10 !== 1'b0) begin n_fail++; $display("FAIL load_masks_tc: got %b want 0", tc10); end
      tick;
      n_chk++; if (q10 !== 4'd2) begin n_fail++; $display("FAIL load_over_en_q: got %0d want 2", q10); end
      n_chk++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL load_over_en_wrap: got %b want 0", wrap10); end
      n_chk++; if (ovf10 !== 1'b1) begin n_fail++; $display("FAIL load_keeps_ovf: got %b want 1", ovf10); end
      clr = 1'b1; d = 4'd5; tick;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL clr_load_q: got %0d want 0", q10); end
      n_chk++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL clr_load_ovf: got %b want 0", ovf10); end
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_async_reset;
      load = 1'b1; d = 4'd9; tick;
      load = 1'b0; en = 1'b1; up = 1'b1; tick;
      load = 1'b1; d = 4'd6; en = 1'b0; tick;
      n_chk++; if (q10 !== 4'd6 || ovf10 !== 1'b1) begin n_fail++; $display("FAIL ares_setup: got q=%0d ovf=%b want q=6 ovf=1", q10, ovf10); end
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1 reset = 1'b0;
      #1;
      n_chk++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL ares_q: got %0d want 0", q10); end
      n_chk++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL ares_ovf: got %b want 0", ovf10); end
      tick;
      reset = 1'b1;
      tick;
      n_chk++; if (q10 !== 4'd1) begin n_fail++; $display("FAIL ares_first_count: got %0d want 1", q10); end
      en = 1'b0; load = 1'b1; d = 4'd9; tick;
      // reset lands before a wrapping edge: the wrap must not appear
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1 reset = 1'b0;
      tick;
      n_chk++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL ares_abort_wrap: got %b want 0", wrap10); end
      n_chk++; if (q10 !== 4'd0 || ovf10 !== 1'b0) begin n_fail++; $display("FAIL ares_abort_state: got q=%0d ovf=%b want q=0 ovf=0", q10, ovf10); end
      reset = 1'b1; en = 1'b0;
   endtask

   task automatic test_mod16;
      logic [3:0] exp_q [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
      load = 1'b1; d = 4'd15; en = 1'b0; tick;
      n_chk++; if (q16 !== 4'd15) begin n_fail++; $display("FAIL m16_load15: got %0d want 15", q16); end
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1;
      n_chk++; if (tc16 !== 1'b1) begin n_fail++; $display("FAIL m16_tc: got %b want 1", tc16); end
      tick;
      n_chk++; if (q16 !== 4'd0) begin n_fail++; $display("FAIL m16_wrap_q: got %0d want 0", q16); end
      n_chk++; if (wrap16 !== 1'b1 || ovf16 !== 1'b1) begin n_fail++; $display("FAIL m16_wrap_flags: got wrap=%b ovf=%b want 1 1", wrap16, ovf16); end
      en = 1'b0; tick;
      n_chk++; if (wrap16 !== 1'b0 || ovf16 !== 1'b1) begin n_fail++; $display("FAIL m16_pulse_end: got wrap=%b ovf=%b want 0 1", wrap16, ovf16); end
      load = 1'b1; d = 4'd3; tick;
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         up = (k % 2 == 0);
         tick;
         n_chk++; if (q16 !== exp_q[k]) begin n_fail++; $display("FAIL m16_toggle[%0d]: got %0d want %0d", k, q16, exp_q[k]); end
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset;
      test_count_up;
      test_count_down;
      test_hold;
      test_load;
      test_async_reset;
      test_mod16;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
